// File: rtl/wb_ram_slave_pkg.sv
// wb_ram_slave_pkg
//   Shared types and constants for the Wishbone RAM responder.
//   - wb_m2s_t : master-to-slave request bundle (addr, data, sel, cyc, stb, we)
//   - wb_s2m_t : slave-to-master response bundle (data, ack)
//   - WB_RAM_ST_* : FSM state encodings, also visible on the debug port
//   - WB_RAM_MISS_DATA : value returned by reads that miss the RAM window
package wb_ram_slave_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
  } wb_m2s_t;

  typedef struct packed {
    logic [31:0] data;
    logic        ack;
  } wb_s2m_t;

  localparam logic [1:0] WB_RAM_ST_IDLE = 2'b00;
  localparam logic [1:0] WB_RAM_ST_WAIT = 2'b01;
  localparam logic [1:0] WB_RAM_ST_ACK  = 2'b10;

  localparam logic [31:0] WB_RAM_MISS_DATA = 32'h0000_0000;

endpackage

// File: rtl/wb_ram_mem.sv
// wb_ram_mem
//   Synchronous single-port word RAM with four byte enables and a registered
//   read port. Kept as its own module so a technology RAM can replace it.
//   Ports:
//     i_clk    in   clock, rising edge
//     i_we     in   write enable (byte lanes gated by i_be)
//     i_re     in   read enable; o_rdata holds its value when low
//     i_be     in   byte enables, lane n = bits 8n+7:8n
//     i_addr   in   word index
//     i_wdata  in   write data
//     o_rdata  out  registered read data
//   The array and the read register are not reset.
module wb_ram_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int n = 0; n < 4; n++) begin
        if (i_be[n]) r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_slave.sv
// wb_ram_slave
//   Wishbone classic single-transfer responder backed by a byte-addressable
//   word RAM. One read or write per bus cycle, ack held for exactly one cycle.
//   Optional wait states are enabled by defining WB_RAM_WAIT_EN; without it
//   the responder always goes IDLE -> ACK and WAIT_CYCLES is ignored.
//   Ports:
//     i_clk        in   clock, rising edge
//     i_rstn       in   asynchronous active-low reset
//     i_wb         in   request bundle (wb_m2s_t)
//     o_wb         out  response bundle (wb_s2m_t), data registered
//     o_dbg_state  out  current FSM state (WB_RAM_ST_* encoding)
//   Handshake: a request is accepted only in IDLE when cyc & stb are high;
//   addr/data/sel/we are latched then and later bus changes are ignored.
//   ack is high for exactly one cycle (the ACK state). With wait states,
//   dropping cyc while waiting aborts the transfer with no write and no ack.
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  wb_m2s_t    i_wb,
  output wb_s2m_t    o_wb,
  output logic [1:0] o_dbg_state
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_sel;
  logic        r_we;
  // Forces the miss value onto the read bus; also provides the reset value 0
  // without needing a reset on the RAM read register.
  logic        r_zero;

`ifdef WB_RAM_WAIT_EN
  logic [3:0]  r_cnt;
`else
  logic [3:0]  w_unused_wait;
  assign w_unused_wait = 4'(WAIT_CYCLES);
`endif

  logic        w_idle;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_sel;
  logic        w_we;
  logic [31:0] w_off;
  logic        w_hit;
  logic [AW-1:0] w_idx;
  logic [1:0]  w_next;
  logic        w_to_ack;
  logic        w_mem_we;
  logic        w_mem_re;
  logic [31:0] w_rdata;

  assign w_idle = (r_state == WB_RAM_ST_IDLE);
  assign w_req  = i_wb.cyc & i_wb.stb;

  // With zero wait states the RAM is accessed on the same edge that accepts
  // the request, so in IDLE the live bus fields drive the decode.
  assign w_addr = w_idle ? i_wb.addr : r_addr;
  assign w_data = w_idle ? i_wb.data : r_data;
  assign w_sel  = w_idle ? i_wb.sel  : r_sel;
  assign w_we   = w_idle ? i_wb.we   : r_we;

  // Unsigned offset: addresses below BASE_ADDR wrap to large values and miss.
  assign w_off = w_addr - BASE_ADDR;
  assign w_hit = (w_off < SPAN);
  assign w_idx = w_off[AW+1:2];

  always_comb begin
    w_next = r_state;
    case (r_state)
      WB_RAM_ST_IDLE: begin
        if (w_req) begin
`ifdef WB_RAM_WAIT_EN
          w_next = (WAIT_CYCLES > 0) ? WB_RAM_ST_WAIT : WB_RAM_ST_ACK;
`else
          w_next = WB_RAM_ST_ACK;
`endif
        end
      end
`ifdef WB_RAM_WAIT_EN
      WB_RAM_ST_WAIT: begin
        if (!i_wb.cyc)       w_next = WB_RAM_ST_IDLE;
        else if (r_cnt == 0) w_next = WB_RAM_ST_ACK;
      end
`endif
      WB_RAM_ST_ACK:  w_next = WB_RAM_ST_IDLE;
      default:        w_next = WB_RAM_ST_IDLE;
    endcase
  end

  // ACK never loops on itself, so entering it is just w_next == ACK.
  // Write commit and read capture both happen on that edge.
  assign w_to_ack = (w_next == WB_RAM_ST_ACK);
  assign w_mem_we = w_to_ack & w_we & w_hit;
  assign w_mem_re = w_to_ack & ~w_we & w_hit;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= WB_RAM_ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_zero  <= 1'b1;
`ifdef WB_RAM_WAIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_idle && w_req) begin
        r_addr <= i_wb.addr;
        r_data <= i_wb.data;
        r_sel  <= i_wb.sel;
        r_we   <= i_wb.we;
      end
`ifdef WB_RAM_WAIT_EN
      if (w_idle && w_req) begin
        r_cnt <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if ((r_state == WB_RAM_ST_WAIT) && (r_cnt != 0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
`endif
      if (w_to_ack && !w_we) r_zero <= ~w_hit;
    end
  end

  wb_ram_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_be    (w_sel),
    .i_addr  (w_idx),
    .i_wdata (w_data),
    .o_rdata (w_rdata)
  );

  assign o_wb.data   = r_zero ? WB_RAM_MISS_DATA : w_rdata;
  assign o_wb.ack    = (r_state == WB_RAM_ST_ACK);
  assign o_dbg_state = r_state;

endmodule
